// File: rtl/gcm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcm_pkg : shared widths and entry layout for the GCM output path      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package gcm_pkg;

  localparam int BLK_BITS      = 128;
  localparam int WORD_BITS     = 32;
  localparam int WORDS_PER_BLK = BLK_BITS / WORD_BITS;

  typedef struct packed {
    logic                last;
    logic [BLK_BITS-1:0] blk;
  } entry_t;

  // Index width that stays legal when only one value is possible.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blk_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blk_fifo : synchronous FIFO of {last, blk} entries with last-bit patch|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module blk_fifo
  import gcm_pkg::*;
#(
  parameter int WIDTH = BLK_BITS + 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  input  logic                   patch_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    newest;
  logic             push_ok, pop_ok;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign newest    = wr_ptr_q - 1'b1;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read beyond count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end else if (patch_last && !empty) begin
      mem_q[newest][WIDTH-1] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gcm_out_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcm_out_packer : buffers GCM result blocks and streams 32-bit words   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gcm_out_packer #(
  parameter int BLK_BITS  = gcm_pkg::BLK_BITS,
  parameter int WORD_BITS = gcm_pkg::WORD_BITS,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BLK_BITS-1:0]  in_blk,
  input  logic                 in_store,
  input  logic                 in_done,
  output logic                 in_full,
  output logic                 overflow,
  input  logic                 err_clr,
  output logic [WORD_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);

  localparam int WPB = BLK_BITS / WORD_BITS;
  localparam int IW  = gcm_pkg::idx_bits(WPB);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WPB - 1);

  typedef struct packed {
    logic                last;
    logic [BLK_BITS-1:0] blk;
  } ent_t;

  logic          unrel_q, unrel_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  ent_t          head, push_ent;
  logic          fire, pop, accept, patch;

  blk_fifo #(
    .WIDTH (BLK_BITS + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_data  (push_ent),
    .pop        (pop),
    .head_data  (head),
    .patch_last (patch),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // The unreleased entry is always the newest, so the head is released
  // whenever the FIFO holds more entries than the unreleased one.
  always_comb begin
    m_axis_tvalid = !fifo_empty && (count != CW'(unrel_q));
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (m_axis_tvalid) begin
      for (int i = 0; i < WPB; i++) begin
        if (idx_q == IW'(i)) begin
          m_axis_tdata = head.blk[BLK_BITS-1-i*WORD_BITS -: WORD_BITS];
        end
      end
      m_axis_tlast = head.last && (idx_q == LAST_IDX);
    end
  end

  always_comb begin
    fire          = m_axis_tvalid && m_axis_tready;
    pop           = fire && (idx_q == LAST_IDX);
    accept        = in_store && (!fifo_full || pop);
    // A dropped store leaves the pending entry alone; in_done still closes it.
    patch         = in_done && !accept && unrel_q;
    push_ent.last = in_done;
    push_ent.blk  = in_blk;

    unrel_d = unrel_q;
    if (accept) begin
      unrel_d = !in_done;
    end else if (patch) begin
      unrel_d = 1'b0;
    end

    idx_d = idx_q;
    if (fire) begin
      idx_d = pop ? '0 : idx_q + 1'b1;
    end

    overflow_d = overflow_q;
    if (in_store && !accept) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unrel_q    <= 1'b0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      unrel_q    <= unrel_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_full  = fifo_full;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_gcm_out_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gcm_out_packer : scoreboard + vector-table bench for the packer    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_gcm_out_packer;

  localparam int BB  = 128;
  localparam int WB  = 32;
  localparam int D   = 4;
  localparam int WPB = BB / WB;

  localparam logic [BB-1:0] BLK_A = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [BB-1:0] BLK_B = 128'hffeeddcc_bbaa9988_77665544_33221100;

  logic          clk = 1'b0;
  logic          reset;
  logic [BB-1:0] in_blk;
  logic          in_store, in_done, err_clr, m_axis_tready;
  logic          in_full, overflow, m_axis_tvalid, m_axis_tlast;
  logic [WB-1:0] m_axis_tdata;

  always #5 clk = ~clk;

  gcm_out_packer #(.BLK_BITS(BB), .WORD_BITS(WB), .DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_blk        (in_blk),
    .in_store      (in_store),
    .in_done       (in_done),
    .in_full       (in_full),
    .overflow      (overflow),
    .err_clr       (err_clr),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  typedef struct {
    logic [WB-1:0] data;
    bit            last;
  } word_t;

  typedef struct {
    bit            st, dn, clr, rdy;
    logic [BB-1:0] blk;
    bit            e_full, e_ovf;
  } vec_t;

  word_t exp_q[$];
  vec_t  tbl[23];
  int    vecs = 0;
  int    fails = 0;
  int    words_seen = 0;

  // Reference model state
  int            m_cnt, m_rel, m_idx;
  bit            m_unrel, m_ovf;
  logic [BB-1:0] m_pend;

  task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [BB-1:0] mk_blk(input int i);
    return {8'(i), 24'h111111, 8'(i), 24'h222222, 8'(i), 24'h333333, 8'(i), 24'h444444};
  endfunction

  task automatic push_words(input logic [BB-1:0] b, input bit last);
    word_t w;
    for (int i = 0; i < WPB; i++) begin
      w.data = b[BB-1-i*WB -: WB];
      w.last = last && (i == WPB - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_idx = 0; m_unrel = 0; m_ovf = 0; m_pend = '0;
    exp_q.delete();
  endtask

  // Called at a negedge: drives one cycle of inputs, checks the word on the
  // bus against the scoreboard, advances the model, returns at the next negedge.
  task automatic step(input bit st, input bit dn, input logic [BB-1:0] b, input bit rdy, input bit clr);
    bit hs, pop, acc;
    in_store = st; in_done = dn; in_blk = b; m_axis_tready = rdy; err_clr = clr;
    chk("tvalid", BB'(m_axis_tvalid), BB'(m_rel > 0));
    if (m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        vecs++; fails++;
        $display("FAIL unexpected_word: got %h want none", m_axis_tdata);
      end else begin
        chk("tdata", BB'(m_axis_tdata), BB'(exp_q[0].data));
        chk("tlast", BB'(m_axis_tlast), BB'(exp_q[0].last));
        if (rdy) begin
          void'(exp_q.pop_front());
          words_seen++;
        end
      end
    end
    hs  = (m_rel > 0) && rdy;
    pop = hs && (m_idx == WPB - 1);
    acc = st && ((m_cnt < D) || pop);
    if (st && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    if (acc) begin
      if (m_unrel) begin push_words(m_pend, 1'b0); m_rel++; end
      if (dn) begin push_words(b, 1'b1); m_rel++; m_unrel = 1'b0; end
      else    begin m_pend = b; m_unrel = 1'b1; end
      m_cnt++;
    end else if (dn && m_unrel) begin
      push_words(m_pend, 1'b1); m_rel++; m_unrel = 1'b0;
    end
    if (hs) begin
      if (pop) begin m_idx = 0; m_cnt--; m_rel--; end
      else m_idx++;
    end
    @(posedge clk);
    @(negedge clk);
    in_store = 1'b0; in_done = 1'b0; err_clr = 1'b0;
    chk("in_full", BB'(in_full), BB'(m_cnt == D));
    chk("overflow", BB'(overflow), BB'(m_ovf));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_store = 1'b0; in_done = 1'b0; err_clr = 1'b0;
    m_axis_tready = 1'b0; in_blk = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_tvalid", BB'(m_axis_tvalid), '0);
    chk("rst_tdata", BB'(m_axis_tdata), '0);
    chk("rst_tlast", BB'(m_axis_tlast), '0);
    chk("rst_full", BB'(in_full), '0);
    chk("rst_ovf", BB'(overflow), '0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_left", BB'(exp_q.size()), '0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int base;

    for (int r = 0; r < 23; r++) begin
      tbl[r] = '{st: 0, dn: 0, clr: 0, rdy: 1, blk: '0, e_full: 0, e_ovf: 1};
    end
    for (int r = 0; r < 5; r++) begin
      tbl[r].st = 1; tbl[r].rdy = 0; tbl[r].blk = mk_blk(r + 1);
      tbl[r].e_full = (r >= 3); tbl[r].e_ovf = (r == 4);
    end
    tbl[5].dn = 1; tbl[5].rdy = 0; tbl[5].e_full = 1;
    for (int r = 6; r < 9; r++) tbl[r].e_full = 1;
    tbl[22].clr = 1; tbl[22].e_ovf = 0;

    do_reset();

    // Two stores then a late in_done
    base = words_seen;
    step(1'b1, 1'b0, BLK_A, 1'b1, 1'b0);
    step(1'b1, 1'b0, BLK_B, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    drain();
    chk("t1_words", BB'(words_seen - base), BB'(8));

    // Store and done together: first word the next cycle
    step(1'b1, 1'b1, mk_blk(9), 1'b1, 1'b0);
    chk("t2_first_valid", BB'(m_axis_tvalid), BB'(1));
    drain();

    // Backpressure mid-block
    step(1'b1, 1'b1, mk_blk(10), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drain();

    // Five stores into a depth-4 FIFO with the sink stalled
    do_reset();
    base = words_seen;
    for (int r = 0; r < 23; r++) begin
      step(tbl[r].st, tbl[r].dn, tbl[r].blk, tbl[r].rdy, tbl[r].clr);
      chk("tbl_full", BB'(in_full), BB'(tbl[r].e_full));
      chk("tbl_ovf", BB'(overflow), BB'(tbl[r].e_ovf));
    end
    chk("t4_words", BB'(words_seen - base), BB'(16));

    // Store while full, coinciding with the final-word pop
    do_reset();
    step(1'b1, 1'b0, mk_blk(20), 1'b0, 1'b0);
    step(1'b1, 1'b0, mk_blk(21), 1'b0, 1'b0);
    step(1'b1, 1'b0, mk_blk(22), 1'b0, 1'b0);
    step(1'b1, 1'b1, mk_blk(23), 1'b0, 1'b0);
    chk("t6_full", BB'(in_full), BB'(1));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, mk_blk(24), 1'b1, 1'b0);
    chk("t6_no_ovf", BB'(overflow), BB'(0));
    chk("t6_still_full", BB'(in_full), BB'(1));
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    drain();

    // in_done with nothing pending is ignored
    do_reset();
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t7_idle_valid", BB'(m_axis_tvalid), BB'(0));

    // Reset after two words of a block, then a clean transaction
    step(1'b1, 1'b1, mk_blk(30), 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b1, mk_blk(31), 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
